// File: rtl/rr_cen_reg_pkg.sv
// Shared types and the rotating-priority pick function for the round-robin register arbiter.
// Requests are padded to 16 lanes so one function body serves every legal NREQ.
package rr_cen_reg_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First requesting lane at or after ptr, wrapping at nreq.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [3:0]         ptr,
                                      input int                 nreq);
        pick_t r;
        int    i;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < nreq) begin
                i = int'(ptr) + k;
                if (i >= nreq) begin
                    i = i - nreq;
                end
                if (!r.found && req[i]) begin
                    r.found = 1'b1;
                    r.idx   = 4'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cen_areset_reg.sv
// Clock-enabled register with asynchronous active-low clear.
module cen_areset_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rr_cen_reg_arbiter.sv
// Round-robin write arbiter for one shared register, with a guard interval of HOLD
// idle cycles after every accepted write.
module rr_cen_reg_arbiter
    import rr_cen_reg_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic [$clog2(NREQ)-1:0] q_src,
    output logic                    q_upd,
    output logic                    busy
);

    localparam int IDXW = $clog2(NREQ);

    state_t                state_q, state_d;
    logic [IDXW-1:0]       ptr_q, ptr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  q_upd_q, q_upd_d;

    logic [MAX_REQ-1:0]    req_pad;
    pick_t                 pick;
    logic [IDXW-1:0]       winner;
    logic                  accept;
    logic [WIDTH-1:0]      data_win;
    logic [IDXW+WIDTH-1:0] reg_q;

    always_comb begin
        req_pad            = '0;
        req_pad[NREQ-1:0]  = req;
    end

    assign pick   = rr_pick(req_pad, 4'(ptr_q), NREQ);
    assign winner = IDXW'(pick.idx);

    // Grant depends only on req, ptr and state; data never reaches an output combinationally.
    always_comb begin
        gnt = '0;
        if (state_q == ST_IDLE && pick.found) begin
            gnt[winner] = 1'b1;
        end
    end

    assign accept   = |(req & gnt);
    assign data_win = data[int'(winner)*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        q_upd_d = accept;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ptr_d = (winner == IDXW'(NREQ - 1)) ? '0 : winner + IDXW'(1);
                    if (HOLD > 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = 4'(HOLD - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            q_upd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            q_upd_q <= q_upd_d;
        end
    end

    cen_areset_reg #(
        .W(IDXW + WIDTH)
    ) u_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (accept),
        .d    ({winner, data_win}),
        .q    (reg_q)
    );

    assign q     = reg_q[WIDTH-1:0];
    assign q_src = reg_q[IDXW+WIDTH-1:WIDTH];
    assign q_upd = q_upd_q;
    assign busy  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_rr_cen_reg_arbiter.sv
// Directed scoreboard bench: three arbiter instances (HOLD = 0, 2, 3) share clock and inputs.
module tb_rr_cen_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;

    // Index 0 -> HOLD=0, 1 -> HOLD=2, 2 -> HOLD=3.
    logic [3:0]  gnt   [3];
    logic [7:0]  q     [3];
    logic [1:0]  q_src [3];
    logic        q_upd [3];
    logic        busy  [3];

    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    rr_cen_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(0)) u_h0 (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .gnt(gnt[0]), .q(q[0]), .q_src(q_src[0]), .q_upd(q_upd[0]), .busy(busy[0])
    );

    rr_cen_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .gnt(gnt[1]), .q(q[1]), .q_src(q_src[1]), .q_upd(q_upd[1]), .busy(busy[1])
    );

    rr_cen_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .gnt(gnt[2]), .q(q[2]), .q_src(q_src[2]), .q_upd(q_upd[2]), .busy(busy[2])
    );

    function automatic logic [31:0] lane(input int i, input logic [7:0] v);
        return 32'(v) << (8 * i);
    endfunction

    task automatic pushExpected(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, e);
            end
        end
    endtask

    task automatic expectCheck(input string tag, input logic [31:0] obs, input logic [31:0] e);
        pushExpected(e);
        checkOutput(tag, obs);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
        req  = r;
        data = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        rst_n = 1'b0;
        #3;
        expectCheck("rst q h2", 32'(q[1]), 32'h0);
        expectCheck("rst q_src h2", 32'(q_src[1]), 32'h0);
        expectCheck("rst busy h2", 32'(busy[1]), 32'h0);
        expectCheck("rst q_upd h2", 32'(q_upd[1]), 32'h0);
        expectCheck("rst gnt h2", 32'(gnt[1]), 32'h0);

        // Reset mid-HOLD, HOLD=3
        doReset();
        tick();
        applyStimulus(4'b0010, lane(1, 8'h3C));
        expectCheck("A gnt", 32'(gnt[2]), 32'b0010);
        tick();
        applyStimulus(4'b0000, 32'h0);
        expectCheck("A q", 32'(q[2]), 32'h3C);
        expectCheck("A q_src", 32'(q_src[2]), 32'd1);
        expectCheck("A busy1", 32'(busy[2]), 32'd1);
        tick();
        expectCheck("A busy2", 32'(busy[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        expectCheck("A rst q", 32'(q[2]), 32'h0);
        expectCheck("A rst q_src", 32'(q_src[2]), 32'h0);
        expectCheck("A rst busy", 32'(busy[2]), 32'h0);
        expectCheck("A rst q_upd", 32'(q_upd[2]), 32'h0);
        applyStimulus(4'b0001, lane(0, 8'h5A));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expectCheck("A post gnt", 32'(gnt[2]), 32'b0001);
        tick();
        expectCheck("A post q", 32'(q[2]), 32'h5A);
        expectCheck("A post q_upd", 32'(q_upd[2]), 32'd1);

        // Single write, HOLD=2
        doReset();
        tick();
        applyStimulus(4'b0100, lane(2, 8'hA5));
        expectCheck("B gnt t", 32'(gnt[1]), 32'b0100);
        tick();
        expectCheck("B q", 32'(q[1]), 32'hA5);
        expectCheck("B q_src", 32'(q_src[1]), 32'd2);
        expectCheck("B q_upd t1", 32'(q_upd[1]), 32'd1);
        expectCheck("B busy t1", 32'(busy[1]), 32'd1);
        expectCheck("B gnt t1", 32'(gnt[1]), 32'd0);
        tick();
        expectCheck("B busy t2", 32'(busy[1]), 32'd1);
        expectCheck("B gnt t2", 32'(gnt[1]), 32'd0);
        expectCheck("B q_upd t2", 32'(q_upd[1]), 32'd0);
        tick();
        expectCheck("B busy t3", 32'(busy[1]), 32'd0);
        expectCheck("B gnt t3", 32'(gnt[1]), 32'b0100);

        // Full contention, HOLD=0
        doReset();
        tick();
        applyStimulus(4'b1111, lane(0, 8'h10) | lane(1, 8'h11) | lane(2, 8'h12) | lane(3, 8'h13));
        for (int k = 0; k < 5; k++) begin
            expectCheck($sformatf("C gnt %0d", k), 32'(gnt[0]), 32'(4'b0001 << (k % 4)));
            tick();
            expectCheck($sformatf("C q %0d", k), 32'(q[0]), 32'h10 + 32'(k % 4));
            expectCheck($sformatf("C q_upd %0d", k), 32'(q_upd[0]), 32'd1);
        end

        // Pointer wrap, HOLD=0
        doReset();
        tick();
        applyStimulus(4'b0010, lane(1, 8'h21) | lane(3, 8'h23));
        expectCheck("D gnt first", 32'(gnt[0]), 32'b0010);
        tick();
        applyStimulus(4'b1010, lane(1, 8'h21) | lane(3, 8'h23));
        expectCheck("D gnt wrap", 32'(gnt[0]), 32'b1000);
        tick();
        expectCheck("D q_src 3", 32'(q_src[0]), 32'd3);
        expectCheck("D q 3", 32'(q[0]), 32'h23);
        expectCheck("D gnt next", 32'(gnt[0]), 32'b0010);
        tick();
        expectCheck("D q_src 1", 32'(q_src[0]), 32'd1);

        // Withdrawal during HOLD, HOLD=2
        doReset();
        tick();
        applyStimulus(4'b0100, lane(2, 8'h77));
        expectCheck("E gnt", 32'(gnt[1]), 32'b0100);
        tick();
        applyStimulus(4'b0001, lane(0, 8'h99));
        expectCheck("E gnt hold1", 32'(gnt[1]), 32'd0);
        tick();
        applyStimulus(4'b0000, 32'h0);
        expectCheck("E gnt hold2", 32'(gnt[1]), 32'd0);
        tick();
        expectCheck("E busy end", 32'(busy[1]), 32'd0);
        expectCheck("E q kept", 32'(q[1]), 32'h77);
        expectCheck("E q_upd", 32'(q_upd[1]), 32'd0);
        applyStimulus(4'b0101, lane(0, 8'h01) | lane(2, 8'h02));
        expectCheck("E ptr kept", 32'(gnt[1]), 32'b0001);

        // Request held across reset release, HOLD=2
        rst_n = 1'b0;
        applyStimulus(4'b0100, lane(2, 8'hA5));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expectCheck("F gnt", 32'(gnt[1]), 32'b0100);
        tick();
        expectCheck("F q", 32'(q[1]), 32'hA5);
        expectCheck("F q_upd", 32'(q_upd[1]), 32'd1);
        expectCheck("F busy", 32'(busy[1]), 32'd1);
        tick();
        expectCheck("F busy2", 32'(busy[1]), 32'd1);
        tick();
        expectCheck("F regrant", 32'(gnt[1]), 32'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_cen_reg_arbiter.md
# rr_cen_reg_arbiter

Round-robin write arbiter for a shared clock-enabled register. It accepts write requests from NREQ requesters and grants one per accepted write. It drives the enable and data of an internal WIDTH-bit posedge clock-enable register, and enforces a programmable guard interval between writes. It sits between independent producers (config ports, debug access, firmware) and a single shared control register.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, register data width
- HOLD, 2, idle guard cycles after each write (0..15; 0 allows back-to-back writes)

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester write request
- data  in  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, combinational; the write is accepted on the edge where req[i] & gnt[i]
- q  out  WIDTH  shared register contents
- q_src  out  clog2(NREQ)  index of the requester that last wrote q
- q_upd  out  1  one-cycle pulse, high the cycle after an accepted write
- busy  out  1  high while in HOLD

## Operation
- FSM has two states:
  - IDLE: gnt may assert.
  - HOLD: gnt is forced to 0.
- Priority pointer ptr ranges 0..NREQ-1. In IDLE the winner is the first i with req[i]=1, scanning ptr, ptr+1, … with wrap modulo NREQ. gnt is one-hot on the winner, or 0 if no req.
- On an accepting edge:
  - q <= data[winner], q_src <= winner, q_upd <= 1
  - ptr <= (winner+1) mod NREQ
  - if HOLD>0: state <= HOLD, cnt <= HOLD-1; otherwise stay IDLE
- In HOLD: cnt decrements each cycle; when cnt==0, the next state is IDLE. ptr and q are unchanged. Requests are ignored, not queued.
- q_upd is 0 on any cycle not following an acceptance.
- Requesters hold req and data stable until granted. Dropping req before the grant is legal and has no side effect.
- Reset (async assert, any state, including mid-HOLD): state=IDLE, ptr=0, cnt=0, q=0, q_src=0, q_upd=0, busy=0. gnt=0 until req rises.
- If rst_n deasserts with req already high, gnt follows combinationally in the first IDLE cycle.

## Timing
- Grant-to-data latency:
  - gnt high in cycle t (IDLE); q/q_src valid from the edge ending t.
  - q_upd high during t+1 only.
  - busy high for cycles t+1 .. t+HOLD.
- Earliest next grant: cycle t+1+HOLD. With HOLD=0, one write per cycle.
- Fairness bound: a continuously requesting requester is granted within NREQ-1 other writes.
- gnt is a combinational path from req, ptr and state only. data has no combinational path to any output.

## Structure
- Package rr_cen_reg_pkg:
  - state typedef (IDLE, HOLD)
  - function rr_pick(req, ptr) returning winner index and found flag
- Sub-module cen_areset_reg, instanced once with width WIDTH+clog2(NREQ) to store q and q_src:
  - ports clk, rst_n, en, d, q
  - posedge clock, clock enable, async active-low reset to 0
  - en = |(req & gnt); d = {winner, data[winner]}
- FSM, ptr, cnt and q_upd flop live in the top module.

## Test plan
- Reset mid-HOLD (NREQ=4, HOLD=3): write 0x3C from requester 1, assert rst_n low in the second busy cycle -> immediately q=0, q_src=0, busy=0, q_upd=0; after release, req[0] gets gnt=4'b0001 on the first cycle.
- Single write (HOLD=2): req[2]=1, data[2]=0xA5 at cycle t -> gnt=4'b0100 in t; q=0xA5, q_src=2, q_upd=1 in t+1; busy in t+1..t+2; gnt=0 in t+1..t+2 even with req[2] held; next gnt in t+3.
- Full contention (HOLD=0): req=4'b1111 held, data[i]=0x10+i -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; q steps 0x10,0x11,0x12,0x13,0x10; q_upd high continuously.
- Pointer wrap: ptr=2 (last winner 1), req=4'b1010 -> first grant 4'b1000 (q_src=3), next grant 4'b0010 (q_src=1).
- Withdrawal: req[0] raised and dropped during HOLD -> no gnt, q unchanged, returns to IDLE after HOLD cycles, ptr unchanged.
- Async reset with req high at release: req=4'b0100 held across reset -> gnt=4'b0100 in the first cycle after rst_n rises; write proceeds as in the single-write scenario.
